gaussian_conv_pipe: RTL and testbench
=====================================

Name: gaussian_conv_pipe

Overview:
- Pipelined, parametrised KxK Gaussian (weighted-average) convolution engine.
- Consumes one packed KxK pixel window per accepted transfer and produces one filtered pixel.
- Integer coefficients are runtime-programmable; normalisation is by right shift with round-half-up and saturation.
- Sits between the line-buffer/window generator and the downstream edge/threshold stage; valid/ready on both sides.

Parameters:
- PIX_W, 8, pixel width in bits (unsigned).
- K, 7, kernel side length; odd, legal values 3, 5, 7.
- COEF_W, 8, coefficient width in bits (unsigned).
- SHIFT, 8, normalisation right-shift; a coefficient sum of 2^SHIFT gives unity gain.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_window  in  K*K*PIX_W  packed window, row-major; pixel (r,c) at bits [(K*K-1-(r*K+c))*PIX_W +: PIX_W], so (0,0) is the MSB slice.
- in_valid  in  1  window valid.
- in_ready  out  1  block can accept a window this cycle.
- bypass  in  1  sampled with each accepted window; 1 = output the centre pixel unfiltered.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  6  coefficient index r*K+c; writes with index >= K*K are ignored.
- coef_data  in  COEF_W  coefficient value.
- out_pixel  out  PIX_W  filtered pixel.
- out_valid  out  1  out_pixel valid.
- out_ready  in  1  downstream accepts.

Behaviour:
- Reset (async, rst=1):
  - All stage valid bits = 0; out_valid = 0; out_pixel = 0.
  - Coefficients = 0 except centre index (K*K-1)/2, which = 2^SHIFT (identity kernel). Requires SHIFT < COEF_W; SHIFT=8 with COEF_W=8 is illegal, so elaborate with COEF_W >= SHIFT+1 or lower SHIFT; the default build uses COEF_W=9.
  - in_ready = 1 after rst deasserts.
- Pipeline: 3 stages, S1 → S2 → S3.
  - S1: register the K*K products pix*coef, each PIX_W+COEF_W bits, plus the centre pixel and the bypass bit.
  - S2: register K per-row sums.
  - S3: final sum, then round, shift, saturate; S3 drives the outputs.
- Arithmetic:
  - Accumulator width = PIX_W+COEF_W+ceil(log2(K*K)); no intermediate overflow is possible.
  - Result = (sum + 2^(SHIFT-1)) >> SHIFT, saturated to 2^PIX_W-1.
  - If bypass is set, out_pixel = the centre pixel (row (K-1)/2, col (K-1)/2) unchanged.
- Handshake and stalling:
  - adv = !out_valid | out_ready; in_ready = adv.
  - The window is accepted on in_valid & in_ready.
  - When adv = 1, all stages shift by one; S1 valid loads in_valid. Bubbles propagate and are not compressed.
  - When adv = 0, all stage registers hold and out_pixel/out_valid stay stable.
- Latency and throughput:
  - Accept at cycle t gives out_valid at t+3 with no stall; one result per cycle at full rate.
  - Ordering is strictly preserved.
- Coefficient writes:
  - Write takes effect at the next edge and applies to windows accepted on later cycles.
  - A window accepted in the same cycle as a write uses the old value.
  - Windows already in flight are unaffected.
  - Writes are allowed at any time, including during stalls.
- Reset mid-operation: in-flight results are discarded, out_valid drops immediately, and coefficients return to the identity kernel.
- Simultaneous out_ready=1 and new accept while S3 is valid: S3 is handed off and replaced in the same edge; no loss and no duplication.

Test Plan:
- Identity after reset (K=7): windows with centre pixel = 37, 200, 0 and other pixels random → out_pixel 37, 200, 0 at accept+3 cycles.
- Uniform box: write all 49 coefs = 5, window all 100 → 24500+128 >> 8 = 96.
- Saturation: all coefs 10, window all 255 → sum 124950 >> 8 = 488 → out_pixel = 255.
- Backpressure: stream 10 windows while holding out_ready=0 for 5 cycles mid-stream.
  - in_ready drops while out_valid is held.
  - All 10 results arrive in order with no loss or duplication.
  - out_pixel is stable during the stall.
- Coefficient write timing:
  - Same-cycle write of centre=128 while accepting window A (centre 200), then accept B (centre 200).
  - A → 200, B → (200*128+128) >> 8 = 100.
- Bypass and reset:
  - bypass=1 with a box kernel, centre 77 → out 77.
  - Assert rst with 3 results in flight → out_valid = 0 immediately and no stale results after release.
- Repeat the box and identity tests for K=3 and K=5 builds.

Source files
------------

// File: rtl/gaussian_conv_pipe_if.sv
// ---------------------------------------------------------------------------
// gaussian_conv_pipe_if
// Handshake and coefficient bus for the KxK Gaussian convolution engine.
//   in_window  packed KxK window, row-major, pixel (0,0) in the MSB slice
//   in_valid   window valid               in_ready  engine can accept
//   bypass     pass the centre pixel through unfiltered (sampled on accept)
//   coef_we    coefficient write strobe   coef_addr index r*K+c
//   coef_data  coefficient value
//   out_pixel  filtered pixel             out_valid out_pixel valid
//   out_ready  downstream accepts
// master = window generator / host side, slave = convolution engine.
// ---------------------------------------------------------------------------
interface gaussian_conv_pipe_if #(
  parameter int PIX_W  = 8,
  parameter int K      = 7,
  parameter int COEF_W = 9
);
  logic [K*K*PIX_W-1:0] in_window;
  logic                 in_valid;
  logic                 in_ready;
  logic                 bypass;
  logic                 coef_we;
  logic [5:0]           coef_addr;
  logic [COEF_W-1:0]    coef_data;
  logic [PIX_W-1:0]     out_pixel;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output in_window, in_valid, bypass, coef_we, coef_addr, coef_data, out_ready,
    input  in_ready, out_pixel, out_valid
  );

  modport slave (
    input  in_window, in_valid, bypass, coef_we, coef_addr, coef_data, out_ready,
    output in_ready, out_pixel, out_valid
  );
endinterface

// File: rtl/gaussian_conv_pipe.sv
// ---------------------------------------------------------------------------
// gaussian_conv_pipe
// Three-stage pipelined KxK weighted-average convolution with runtime
// programmable integer coefficients, round-half-up normalisation by SHIFT and
// saturation to PIX_W bits.
//   S1: K*K products pix*coef, centre pixel, bypass bit
//   S2: K per-row sums
//   S3: final sum, round, shift, saturate -> out_pixel / out_valid
// Ports:
//   clk  clock (rising edge)
//   rst  asynchronous active-high reset (pipeline empty, identity kernel)
//   bus  gaussian_conv_pipe_if.slave (window in, pixel out, coef writes)
// The whole pipeline advances together whenever the output register is empty
// or being drained, so bubbles are kept and ordering is preserved.
// ---------------------------------------------------------------------------
module gaussian_conv_pipe #(
  parameter int PIX_W  = 8,
  parameter int K      = 7,
  parameter int COEF_W = 9,
  parameter int SHIFT  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  gaussian_conv_pipe_if.slave   bus
);
  localparam int N      = K * K;
  localparam int CENTRE = (N - 1) / 2;
  localparam int PROD_W = PIX_W + COEF_W;
  localparam int ROW_W  = PROD_W + $clog2(K);
  localparam int ACC_W  = PROD_W + $clog2(N);
  localparam int RND_W  = ACC_W + 1;   // one spare bit so the rounding add cannot wrap

  localparam logic [COEF_W-1:0] UNITY   = COEF_W'(1) << SHIFT;
  localparam logic [RND_W-1:0]  ROUND   = RND_W'(1) << (SHIFT - 1);
  localparam logic [RND_W-1:0]  PIX_MAX = {{(RND_W-PIX_W){1'b0}}, {PIX_W{1'b1}}};

  if (K != 3 && K != 5 && K != 7) begin : g_bad_k
    $error("gaussian_conv_pipe: K must be 3, 5 or 7");
  end
  if (SHIFT < 1 || SHIFT >= COEF_W) begin : g_bad_shift
    $error("gaussian_conv_pipe: need 1 <= SHIFT < COEF_W for an identity kernel");
  end

  // -------------------------------------------------------------------------
  // Handshake: every stage moves when the output slot is free or draining.
  // -------------------------------------------------------------------------
  logic adv;
  assign adv          = !bus.out_valid || bus.out_ready;
  assign bus.in_ready = adv;

  // -------------------------------------------------------------------------
  // Coefficient bank, returns to the identity kernel on reset.
  // -------------------------------------------------------------------------
  logic [COEF_W-1:0] coef [N];

  // NOTE: this small register bank is reset on purpose -- the identity kernel
  // is part of the block's defined state, unlike the datapath registers below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N; i++) coef[i] <= (i == CENTRE) ? UNITY : '0;
    end else begin
      // Out-of-range indices match no entry and are therefore dropped.
      for (int i = 0; i < N; i++) begin
        if (bus.coef_we && bus.coef_addr == 6'(i)) coef[i] <= bus.coef_data;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Window unpack: index i = r*K+c sits at slice N-1-i ((0,0) is the MSB).
  // -------------------------------------------------------------------------
  logic [PIX_W-1:0] pix [N];
  for (genvar i = 0; i < N; i++) begin : g_unpack
    assign pix[i] = bus.in_window[(N-1-i)*PIX_W +: PIX_W];
  end

  // -------------------------------------------------------------------------
  // Pipeline registers.
  // -------------------------------------------------------------------------
  logic [PROD_W-1:0] s1_prod [N];
  logic [PIX_W-1:0]  s1_centre, s2_centre;
  logic              s1_bypass, s2_bypass;
  logic              s1_valid, s2_valid;
  logic [ROW_W-1:0]  row_sum [K];
  logic [ROW_W-1:0]  s2_row  [K];
  logic [PIX_W-1:0]  s3_pixel;

  // S2 input: per-row sums of the S1 products.
  always_comb begin
    for (int r = 0; r < K; r++) begin
      logic [ROW_W-1:0] acc;
      acc = '0;
      for (int c = 0; c < K; c++) acc = acc + ROW_W'(s1_prod[r*K+c]);
      row_sum[r] = acc;
    end
  end

  // S3 input: final sum, round half up, shift, saturate (or bypass).
  always_comb begin
    logic [ACC_W-1:0] total;
    logic [RND_W-1:0] shifted;
    // NOTE: combinational blocks use blocking '=' and assign every output
    // first, so the accumulation reads in order and no latch can be inferred.
    total = '0;
    for (int r = 0; r < K; r++) total = total + ACC_W'(s2_row[r]);
    shifted = (RND_W'(total) + ROUND) >> SHIFT;
    if (s2_bypass)              s3_pixel = s2_centre;
    else if (shifted > PIX_MAX) s3_pixel = '1;
    else                        s3_pixel = shifted[PIX_W-1:0];
  end

  // NOTE: datapath registers carry no reset; only the valid bits and the
  // visible output need a defined value, and the payload is qualified by them.
  always_ff @(posedge clk) begin
    if (adv) begin
      for (int i = 0; i < N; i++) s1_prod[i] <= PROD_W'(pix[i]) * PROD_W'(coef[i]);
      s1_centre <= pix[CENTRE];
      s1_bypass <= bus.bypass;
      for (int r = 0; r < K; r++) s2_row[r] <= row_sum[r];
      s2_centre <= s1_centre;
      s2_bypass <= s1_bypass;
    end
  end

  // NOTE: all state updates use non-blocking '<=' so every stage samples the
  // pre-edge value of its predecessor and the shift happens in one step.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid      <= 1'b0;
      s2_valid      <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_pixel <= '0;
    end else if (adv) begin
      s1_valid      <= bus.in_valid;
      s2_valid      <= s1_valid;
      bus.out_valid <= s2_valid;
      if (s2_valid) bus.out_pixel <= s3_pixel;
    end
  end
endmodule

// File: tb/tb_gaussian_conv_pipe.sv
// ---------------------------------------------------------------------------
// tb_gaussian_conv_pipe
// Main instance K=7 checked by a scoreboard fed from an integer model of the
// weighted average; directed tests pin the model with literal results.
// Small K=3 and K=5 instances repeat the identity and box tests.
// ---------------------------------------------------------------------------
module tb_gaussian_conv_pipe;
  localparam int PIX_W = 8, COEF_W = 9, SHIFT = 8;
  localparam int NW = 49;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  gaussian_conv_pipe_if #(.PIX_W(PIX_W), .K(7), .COEF_W(COEF_W)) bus ();
  gaussian_conv_pipe_if #(.PIX_W(PIX_W), .K(5), .COEF_W(COEF_W)) b5 ();
  gaussian_conv_pipe_if #(.PIX_W(PIX_W), .K(3), .COEF_W(COEF_W)) b3 ();

  gaussian_conv_pipe #(.PIX_W(PIX_W), .K(7), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut   (.clk(clk), .rst(rst), .bus(bus));
  gaussian_conv_pipe #(.PIX_W(PIX_W), .K(5), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut_k5 (.clk(clk), .rst(rst), .bus(b5));
  gaussian_conv_pipe #(.PIX_W(PIX_W), .K(3), .COEF_W(COEF_W), .SHIFT(SHIFT)) dut_k3 (.clk(clk), .rst(rst), .bus(b3));

  int n_cmp = 0;
  int n_bad = 0;
  int n_rx  = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Reference model: plain integer weighted average over the 7x7 window.
  // -------------------------------------------------------------------------
  int mc [NW];
  int exp_q [$];
  bit held_valid = 1'b0;
  int held_pix   = 0;

  function automatic void model_reset();
    for (int i = 0; i < NW; i++) mc[i] = 0;
    mc[24] = 256;
  endfunction

  function automatic int model_eval(input logic [NW*8-1:0] w, input logic byp);
    int sum = 0;
    int r;
    if (byp) return int'(w[(NW-1-24)*8 +: 8]);
    for (int i = 0; i < NW; i++) sum += int'(w[(NW-1-i)*8 +: 8]) * mc[i];
    r = (sum + 128) / 256;
    return (r > 255) ? 255 : r;
  endfunction

  // Compare process: everything sampled on the falling edge, i.e. the values
  // the DUT will see at the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_reset();
      held_valid = 1'b0;
    end else begin
      if (held_valid) begin
        check("stall_hold_valid", bus.out_valid, 1);
        check("stall_hold_pixel", bus.out_pixel, held_pix);
      end
      check("in_ready_rule", bus.in_ready, !bus.out_valid || bus.out_ready);
      if (bus.out_valid && bus.out_ready) begin
        n_rx++;
        if (exp_q.size() == 0) check("sb_unexpected_output", 1, 0);
        else                   check("sb_pixel", bus.out_pixel, exp_q.pop_front());
      end
      if (bus.in_valid && bus.in_ready) exp_q.push_back(model_eval(bus.in_window, bus.bypass));
      if (bus.coef_we && bus.coef_addr < 6'd49) mc[bus.coef_addr] = int'(bus.coef_data);
      held_valid = bus.out_valid && !bus.out_ready;
      held_pix   = int'(bus.out_pixel);
    end
  end

  // -------------------------------------------------------------------------
  // Stimulus helpers (all start and end 2ns after a rising edge).
  // -------------------------------------------------------------------------
  task automatic sync();
    @(posedge clk); #2;
  endtask

  function automatic logic [NW*8-1:0] uni_win(input int centre, input int other);
    logic [NW*8-1:0] w;
    for (int i = 0; i < NW; i++) w[(NW-1-i)*8 +: 8] = 8'((i == 24) ? centre : other);
    return w;
  endfunction

  function automatic logic [NW*8-1:0] rand_win(input int centre);
    logic [NW*8-1:0] w;
    for (int i = 0; i < NW; i++) w[(NW-1-i)*8 +: 8] = 8'((i == 24) ? centre : int'($urandom_range(0, 255)));
    return w;
  endfunction

  task automatic accept(input logic [NW*8-1:0] w, input logic byp,
                        input logic we, input logic [5:0] a, input logic [8:0] d);
    int n = 0;
    bus.in_window = w; bus.in_valid = 1'b1; bus.bypass = byp;
    bus.coef_we = we;  bus.coef_addr = a;   bus.coef_data = d;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 100) begin check("accept_timeout", 0, 1); break; end
    end
    sync();
    bus.in_valid = 1'b0; bus.coef_we = 1'b0;
  endtask

  task automatic wr_all(input int val);
    for (int i = 0; i < NW; i++) begin
      bus.coef_we = 1'b1; bus.coef_addr = 6'(i); bus.coef_data = 9'(val);
      sync();
    end
    bus.coef_we = 1'b0;
  endtask

  // Pipeline must be empty: result is visible exactly three cycles later.
  task automatic check_lat(input int exp, input string name);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check({name, "_valid_cycle", $sformatf("%0d", j)}, bus.out_valid, (j == 3));
    end
    check(name, bus.out_pixel, exp);
    sync();
  endtask

  task automatic expect_next(input int exp, input string name);
    int n = 0;
    forever begin
      @(negedge clk);
      if (bus.out_valid && bus.out_ready) begin check(name, bus.out_pixel, exp); break; end
      n++;
      if (n > 50) begin check({name, "_timeout"}, 0, 1); break; end
    end
  endtask

  // Small-kernel instances.
  function automatic logic [199:0] small_win(input int k, input int centre, input int other);
    logic [199:0] w = '0;
    int n = k * k;
    for (int i = 0; i < n; i++) w[(n-1-i)*8 +: 8] = 8'((i == (n-1)/2) ? centre : other);
    return w;
  endfunction

  task automatic small_drive(input int k, input logic [199:0] w, input logic v,
                             input logic we, input logic [5:0] a, input logic [8:0] d);
    if (k == 3) begin
      b3.in_window = w[71:0]; b3.in_valid = v; b3.coef_we = we; b3.coef_addr = a; b3.coef_data = d;
    end else begin
      b5.in_window = w;       b5.in_valid = v; b5.coef_we = we; b5.coef_addr = a; b5.coef_data = d;
    end
  endtask

  task automatic small_expect(input int k, input int exp, input string name);
    for (int j = 1; j <= 3; j++) begin
      @(negedge clk);
      check({name, "_valid_cycle", $sformatf("%0d", j)},
            (k == 3) ? b3.out_valid : b5.out_valid, (j == 3));
    end
    check(name, (k == 3) ? b3.out_pixel : b5.out_pixel, exp);
    sync();
  endtask

  task automatic run_small(input int k, input int box_exp);
    string tag = $sformatf("k%0d", k);
    small_drive(k, small_win(k, 37, 9), 1'b1, 1'b0, 6'd0, 9'd0); sync();
    small_drive(k, '0, 1'b0, 1'b0, 6'd0, 9'd0);
    small_expect(k, 37, {tag, "_identity"});
    for (int i = 0; i < k * k; i++) begin
      small_drive(k, '0, 1'b0, 1'b1, 6'(i), 9'd5); sync();
    end
    small_drive(k, small_win(k, 100, 100), 1'b1, 1'b0, 6'd0, 9'd0); sync();
    small_drive(k, '0, 1'b0, 1'b0, 6'd0, 9'd0);
    small_expect(k, box_exp, {tag, "_box"});
  endtask

  // -------------------------------------------------------------------------
  // Directed sequence.
  // -------------------------------------------------------------------------
  initial begin
    int base;
    rst = 1'b1;
    bus.in_window = '0; bus.in_valid = 1'b0; bus.bypass = 1'b0; bus.out_ready = 1'b1;
    bus.coef_we = 1'b0; bus.coef_addr = '0; bus.coef_data = '0;
    b3.out_ready = 1'b1; b3.bypass = 1'b0; b5.out_ready = 1'b1; b5.bypass = 1'b0;
    small_drive(3, '0, 1'b0, 1'b0, 6'd0, 9'd0);
    small_drive(5, '0, 1'b0, 1'b0, 6'd0, 9'd0);
    model_reset();

    @(negedge clk);
    check("reset_out_valid", bus.out_valid, 0);
    check("reset_out_pixel", bus.out_pixel, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("reset_in_ready", bus.in_ready, 1);
    sync();

    // Identity kernel straight out of reset.
    accept(rand_win(37), 1'b0, 1'b0, 6'd0, 9'd0);  check_lat(37,  "identity_37");
    accept(rand_win(200), 1'b0, 1'b0, 6'd0, 9'd0); check_lat(200, "identity_200");
    accept(rand_win(0), 1'b0, 1'b0, 6'd0, 9'd0);   check_lat(0,   "identity_0");

    // Uniform box: 49*5*100 = 24500, +128 >> 8 = 96.
    wr_all(5);
    accept(uni_win(100, 100), 1'b0, 1'b0, 6'd0, 9'd0); check_lat(96, "box_100");

    // Saturation: 49*10*255 = 124950 -> 488 -> 255.
    wr_all(10);
    accept(uni_win(255, 255), 1'b0, 1'b0, 6'd0, 9'd0); check_lat(255, "saturate");

    // Bypass passes the centre through regardless of the kernel.
    accept(uni_win(77, 100), 1'b1, 1'b0, 6'd0, 9'd0); check_lat(77, "bypass_77");

    // Reset with three results in flight.
    accept(rand_win(11), 1'b0, 1'b0, 6'd0, 9'd0);
    accept(rand_win(22), 1'b0, 1'b0, 6'd0, 9'd0);
    accept(rand_win(33), 1'b0, 1'b0, 6'd0, 9'd0);
    rst = 1'b1;
    #1;
    check("midreset_out_valid", bus.out_valid, 0);
    check("midreset_out_pixel", bus.out_pixel, 0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      check("no_stale_after_reset", bus.out_valid, 0);
    end
    sync();
    accept(rand_win(37), 1'b0, 1'b0, 6'd0, 9'd0); check_lat(37, "identity_after_reset");

    // Same-cycle coefficient write uses the old value; the next window sees it.
    accept(rand_win(200), 1'b0, 1'b1, 6'd24, 9'd128);
    accept(rand_win(200), 1'b0, 1'b0, 6'd0, 9'd0);
    expect_next(200, "coef_write_same_cycle");
    expect_next(100, "coef_write_next_window");
    sync();

    // Out-of-range write must not disturb the kernel.
    bus.coef_we = 1'b1; bus.coef_addr = 6'd49; bus.coef_data = 9'd3; sync();
    bus.coef_we = 1'b0;
    accept(uni_win(50, 255), 1'b0, 1'b0, 6'd0, 9'd0); check_lat(25, "ignored_addr_49");

    // Backpressure: 10 windows, out_ready held low 5 cycles mid-stream.
    base = n_rx;
    fork
      begin
        for (int i = 0; i < 10; i++)
          accept(rand_win(int'($urandom_range(0, 255))), 1'b0, 1'b0, 6'd0, 9'd0);
      end
      begin
        repeat (5) sync();
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("bp_out_valid_held", bus.out_valid, 1);
        check("bp_in_ready_low", bus.in_ready, 0);
        repeat (5) sync();
        bus.out_ready = 1'b1;
      end
    join
    repeat (8) @(negedge clk);
    check("bp_result_count", n_rx - base, 10);
    sync();

    run_small(3, 18);   // 9*500 = 4500, +128 >> 8
    run_small(5, 49);   // 25*500 = 12500, +128 >> 8

    repeat (4) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d compared so far", n_cmp);
    $fatal(1, "watchdog");
  end
endmodule
